uart_stream_arbiter: RTL and testbench
======================================

Name: uart_stream_arbiter

Overview:
- Shares the single uart_turbo_transmit instance between two requesters: the bufferizer audio stream (16-bit samples) and YIN pitch telemetry (11-bit taumin).
- Audio has priority. Taumin is sent as a two-word frame (header 16'hFFFF, then zero-extended taumin), so the host can demultiplex one byte stream.
- Sits between the audio/taumin register stages and the UART transmitter. Starvation guard and drop accounting included.

Parameters:
- WIDTH, 16, UART word width; audio and frame words are this wide.
- TAU_WIDTH, 11, taumin width; must be <= WIDTH-1.
- STARVE_LIMIT, 8, consecutive audio grants allowed while taumin pending before taumin is forced.
- ACK_TIMEOUT, 4, cycles to wait for busy_in rising after a trigger before treating the word as accepted.
- CNT_WIDTH, 16, drop counter width.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_n_in  input  1  asynchronous active-low reset
- audio_in  input  WIDTH  audio sample
- audio_valid_in  input  1  single-cycle strobe, audio_in valid
- taumin_in  input  TAU_WIDTH  pitch period estimate
- taumin_valid_in  input  1  single-cycle strobe, taumin_in valid
- uart_busy_in  input  1  busy_out of transmitter
- uart_data_out  output  WIDTH  word to transmit
- uart_trigger_out  output  1  single-cycle transmit strobe
- audio_drop_count_out  output  CNT_WIDTH  saturating count of overwritten audio samples
- tau_sent_out  output  1  single-cycle pulse when the taumin payload word is triggered

Behaviour:
- Reset (async assert, sync-safe deassert not required here): state IDLE; uart_data_out=0, uart_trigger_out=0, audio_drop_count_out=0, tau_sent_out=0; both pending flags clear, starvation counter 0.
- Holding registers: audio_pend/audio_reg, tau_pend/tau_reg. Strobe captures on the same edge and sets pend.
  - Audio strobe while audio_pend=1: overwrite with the new sample. Increment drop count (saturate at all-ones).
  - Taumin strobe while tau_pend=1: overwrite, newest wins, no count.
  - Strobe on the same cycle the register is consumed: new value captured, pend stays 1, no drop counted.
- Audio escape: audio_reg==16'hFFFF is transmitted as 16'hFFFE. The header value never appears as audio.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE: if uart_busy_in=1, stay.
    - Otherwise choose taumin if tau_pend and (not audio_pend or starve_cnt>=STARVE_LIMIT), or if a frame header was already sent (mid-frame).
    - Else choose audio if audio_pend. Else stay.
    - Go to ISSUE with uart_data_out loaded.
  - Word selection:
    - Audio: data=escaped audio_reg, clear audio_pend. If tau_pend, starve_cnt+1 (saturating), else starve_cnt=0.
    - Taumin, first word: data=16'hFFFF, set mid_frame, snapshot tau_reg to frame register, clear tau_pend.
    - Taumin, second word: data={zeros, frame register}, clear mid_frame, starve_cnt=0, pulse tau_sent_out.
  - ISSUE: uart_trigger_out=1 for exactly this cycle. Next state WAIT_ACK, timer=0.
  - WAIT_ACK: on uart_busy_in=1 go to WAIT_DONE. Otherwise increment timer; at timer==ACK_TIMEOUT-1 return to IDLE.
  - WAIT_DONE: on uart_busy_in=0 go to IDLE.
- Mid-frame rule: once the header is triggered, the payload is the next word sent. Audio cannot interleave between header and payload.
- Latency: strobe into an idle arbiter with UART not busy gives a trigger 2 cycles after the strobe edge (capture, IDLE→ISSUE).
- Back-to-back triggers are separated by at least 3 cycles.
- Reset mid-frame: everything clears. The host sees an orphan header, which its parser discards.

Test Plan:
- Audio only: audio_in=16'h1234 strobe, busy model 10 cycles → one trigger 2 cycles later with data 16'h1234. Second sample after busy falls → second trigger. Drop count stays 0.
- Escape: audio_in=16'hFFFF → uart_data_out=16'hFFFE.
- Taumin frame: taumin_in=11'd345, no audio → triggers carry 16'hFFFF then 16'h0159, with tau_sent_out pulsing on the second.
- Starvation: audio strobe every busy period, STARVE_LIMIT=8, taumin pending → exactly 8 audio words, then header+payload, with no audio between header and payload.
- Overflow: 3 audio strobes while busy held high → drop count=2, only the last sample sent. Taumin strobes 100 then 200 while busy → payload 200.
- Ack timeout: busy tied 0 → each trigger followed by return to IDLE after ACK_TIMEOUT cycles. Assert rst_n_in low mid-WAIT_DONE → outputs 0 asynchronously; after release, no trigger until a new strobe.

Source files
------------

// File: rtl/uart_stream_arbiter.sv
// uart_stream_arbiter: shares one UART transmitter between audio samples
// and framed taumin telemetry; audio wins, with a starvation guard.
module uart_stream_arbiter #(
  parameter int WIDTH        = 16,
  parameter int TAU_WIDTH    = 11,
  parameter int STARVE_LIMIT = 8,
  parameter int ACK_TIMEOUT  = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [WIDTH-1:0]     audio_in,
  input  logic                 audio_valid_in,
  input  logic [TAU_WIDTH-1:0] taumin_in,
  input  logic                 taumin_valid_in,
  input  logic                 uart_busy_in,
  output logic [WIDTH-1:0]     uart_data_out,
  output logic                 uart_trigger_out,
  output logic [CNT_WIDTH-1:0] audio_drop_count_out,
  output logic                 tau_sent_out
);

  localparam int SW  = $clog2(STARVE_LIMIT + 1);
  localparam int TMW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TMW-1:0] T_LAST = TMW'(ACK_TIMEOUT - 1);
  localparam logic [WIDTH-1:0] HDR = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ESC = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_ACK, WAIT_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [TMW-1:0]       timer_q, timer_d;
  logic                 audio_pend_q, audio_pend_d;
  logic [WIDTH-1:0]     audio_q, audio_d;
  logic                 tau_pend_q, tau_pend_d;
  logic [TAU_WIDTH-1:0] tau_q, tau_d;
  logic [TAU_WIDTH-1:0] frame_q, frame_d;
  logic                 mid_frame_q, mid_frame_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 sent_q, sent_d;
  logic                 free, sel_tau, sel_aud;

  always_comb begin
    free    = (state_q == IDLE) && !uart_busy_in;
    sel_tau = free && (mid_frame_q ||
              (tau_pend_q &&
               (!audio_pend_q || starve_q >= STARVE_MAX)));
    sel_aud = free && !sel_tau && audio_pend_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (sel_aud || sel_tau) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        timer_d = '0;
      end
      WAIT_ACK: begin
        if (uart_busy_in) begin
          state_d = WAIT_DONE;
        end else if (timer_q == T_LAST) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_trigger_out = (state_q == ISSUE);
  end

  always_comb begin
    audio_pend_d = audio_pend_q;
    audio_d      = audio_q;
    tau_pend_d   = tau_pend_q;
    tau_d        = tau_q;
    frame_d      = frame_q;
    mid_frame_d  = mid_frame_q;
    starve_d     = starve_q;
    data_d       = data_q;
    drop_d       = drop_q;
    sent_d       = 1'b0;
    unique case (1'b1)
      sel_aud: begin
        data_d       = (audio_q == HDR) ? ESC : audio_q;
        audio_pend_d = 1'b0;
        if (!tau_pend_q) begin
          starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
          starve_d = starve_q + 1'b1;
        end
      end
      sel_tau && mid_frame_q: begin
        data_d      = {{(WIDTH-TAU_WIDTH){1'b0}}, frame_q};
        mid_frame_d = 1'b0;
        starve_d    = '0;
        sent_d      = 1'b1;
      end
      sel_tau && !mid_frame_q: begin
        data_d      = HDR;
        mid_frame_d = 1'b1;
        frame_d     = tau_q;
        tau_pend_d  = 1'b0;
      end
      default: ;
    endcase
    // a strobe landing on the consuming edge is a fresh capture, not a drop
    if (audio_valid_in) begin
      audio_d      = audio_in;
      audio_pend_d = 1'b1;
      if (audio_pend_q && !sel_aud && drop_q != CNT_MAX) begin
        drop_d = drop_q + 1'b1;
      end
    end
    if (taumin_valid_in) begin
      tau_d      = taumin_in;
      tau_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      audio_pend_q <= 1'b0;
      audio_q      <= '0;
      tau_pend_q   <= 1'b0;
      tau_q        <= '0;
      frame_q      <= '0;
      mid_frame_q  <= 1'b0;
      starve_q     <= '0;
      data_q       <= '0;
      drop_q       <= '0;
      sent_q       <= 1'b0;
    end else begin
      audio_pend_q <= audio_pend_d;
      audio_q      <= audio_d;
      tau_pend_q   <= tau_pend_d;
      tau_q        <= tau_d;
      frame_q      <= frame_d;
      mid_frame_q  <= mid_frame_d;
      starve_q     <= starve_d;
      data_q       <= data_d;
      drop_q       <= drop_d;
      sent_q       <= sent_d;
    end
  end

  assign uart_data_out        = data_q;
  assign audio_drop_count_out = drop_q;
  assign tau_sent_out         = sent_q;

endmodule

// File: tb/tb_uart_stream_arbiter.sv
// tb_uart_stream_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level arbitration model.
module tb_uart_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] audio;
  logic        audio_v;
  logic [10:0] tau;
  logic        tau_v;
  logic        busy;
  logic [15:0] data;
  logic        trig;
  logic [15:0] drop;
  logic        tsent;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_stream_arbiter #(
    .WIDTH(16), .TAU_WIDTH(11), .STARVE_LIMIT(8),
    .ACK_TIMEOUT(4), .CNT_WIDTH(16)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .audio_in(audio),
    .audio_valid_in(audio_v),
    .taumin_in(tau),
    .taumin_valid_in(tau_v),
    .uart_busy_in(busy),
    .uart_data_out(data),
    .uart_trigger_out(trig),
    .audio_drop_count_out(drop),
    .tau_sent_out(tsent)
  );

  typedef struct {
    logic        av;
    logic [15:0] a;
    logic        tv;
    logic [10:0] t;
    logic        busy;
    logic        trig;
    logic [15:0] data;
    logic        ts;
    logic [15:0] drop;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    audio_v = 1'b0;
    audio = '0;
    tau_v = 1'b0;
    tau = '0;
    busy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_trig(input string name, output logic [15:0] d,
                           output logic ts);
    d = '0;
    ts = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      audio_v = 1'b0;
      tau_v = 1'b0;
      if (trig) begin
        d = data;
        ts = tsent;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s no trigger within 60 cycles", name);
  endtask

  // transaction-level model state for the random run
  logic        m_ap, m_tp, m_mid;
  logic [15:0] m_a;
  logic [10:0] m_t, m_fr;
  int          m_starve, m_drop;

  initial begin
    vec_t        v[27];
    logic [15:0] d;
    logic        ts;
    logic [15:0] w[10];
    int          nw;

    // reset state
    clr_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_trig", trig, 1'b0);
    chk("rst_data", data, 16'h0000);
    chk("rst_drop", drop, 16'h0000);
    chk("rst_ts", tsent, 1'b0);
    rst_n = 1'b1;

    // vector table, busy held low so every word ends by ack timeout
    for (int i = 0; i < 27; i++) begin
      v[i] = '{default: '0};
      v[i].data = (i < 1)  ? 16'h0000 :
                  (i < 7)  ? 16'h1234 :
                  (i < 13) ? 16'hFFFE :
                  (i < 19) ? 16'hFFFF :
                  (i < 25) ? 16'h0159 : 16'h0002;
      v[i].drop = (i >= 15) ? 16'd1 : 16'd0;
      v[i].trig = (i == 1 || i == 7 || i == 13 ||
                   i == 19 || i == 25);
    end
    v[19].ts = 1'b1;
    v[0].av = 1'b1;  v[0].a = 16'h1234;
    v[2].av = 1'b1;  v[2].a = 16'hFFFF;
    v[3].tv = 1'b1;  v[3].t = 11'd345;
    v[14].av = 1'b1; v[14].a = 16'h0001;
    v[15].av = 1'b1; v[15].a = 16'h0002;
    for (int i = 0; i < 27; i++) begin
      audio_v = v[i].av;
      audio = v[i].a;
      tau_v = v[i].tv;
      tau = v[i].t;
      busy = v[i].busy;
      @(negedge clk);
      chk($sformatf("vec%0d_trig", i), trig, v[i].trig);
      chk($sformatf("vec%0d_data", i), data, v[i].data);
      chk($sformatf("vec%0d_ts", i), tsent, v[i].ts);
      chk($sformatf("vec%0d_drop", i), drop, v[i].drop);
    end

    // overflow while the UART is busy
    do_reset();
    busy = 1'b1;
    audio_v = 1'b1;
    audio = 16'h0A01;
    @(negedge clk);
    audio = 16'h0A02;
    @(negedge clk);
    audio = 16'h0A03;
    tau_v = 1'b1;
    tau = 11'd100;
    @(negedge clk);
    audio_v = 1'b0;
    tau = 11'd200;
    @(negedge clk);
    tau_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("ovf_drop", drop, 16'd2);
    chk("ovf_busy_notrig", trig, 1'b0);
    busy = 1'b0;
    wait_trig("ovf_w0", d, ts);
    chk("ovf_audio", d, 16'h0A03);
    wait_trig("ovf_w1", d, ts);
    chk("ovf_hdr", d, 16'hFFFF);
    chk("ovf_hdr_ts", ts, 1'b0);
    wait_trig("ovf_w2", d, ts);
    chk("ovf_payload", d, 16'd200);
    chk("ovf_payload_ts", ts, 1'b1);

    // starvation guard: audio offered every cycle, one taumin pending
    do_reset();
    tau_v = 1'b1;
    tau = 11'd77;
    audio_v = 1'b1;
    audio = 16'h0001;
    nw = 0;
    for (int c = 0; c < 300 && nw < 10; c++) begin
      @(negedge clk);
      tau_v = 1'b0;
      if (trig) begin
        w[nw] = data;
        nw++;
      end
      audio = audio + 16'd1;
    end
    audio_v = 1'b0;
    chk("starve_words", nw, 10);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("starve_aud%0d", k), w[k] == 16'hFFFF, 1'b0);
    end
    chk("starve_hdr", w[8], 16'hFFFF);
    chk("starve_payload", w[9], 16'd77);

    // async reset in WAIT_DONE, then nothing until a new strobe
    do_reset();
    busy = 1'b1;
    audio_v = 1'b1;
    audio = 16'h1111;
    @(negedge clk);
    audio = 16'h2222;
    @(negedge clk);
    audio_v = 1'b0;
    busy = 1'b0;
    wait_trig("rst_w0", d, ts);
    chk("rst_seq_data", d, 16'h2222);
    busy = 1'b1;
    audio_v = 1'b1;
    audio = 16'h3333;
    @(negedge clk);
    audio_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_drop", drop, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", data, 16'h0000);
    chk("async_rst_drop", drop, 16'h0000);
    chk("async_rst_trig", trig, 1'b0);
    chk("async_rst_ts", tsent, 1'b0);
    clr_in();
    @(negedge clk);
    rst_n = 1'b1;
    nw = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (trig) nw++;
    end
    chk("post_rst_quiet", nw, 0);
    audio_v = 1'b1;
    audio = 16'h4444;
    @(negedge clk);
    audio_v = 1'b0;
    chk("lat_cycle1", trig, 1'b0);
    @(negedge clk);
    chk("lat_cycle2", trig, 1'b1);
    chk("lat_data", data, 16'h4444);

    // randomized run against the model
    do_reset();
    m_ap = 1'b0; m_tp = 1'b0; m_mid = 1'b0;
    m_a = '0; m_t = '0; m_fr = '0;
    m_starve = 0; m_drop = 0;
    begin
      int dly = 0, hold = 0, last_c = -100;
      int stall = 0, max_stall = 0;
      logic lt = 1'b0;
      logic [15:0] e;
      logic ets, cons_a;
      for (int c = 0; c < 3000; c++) begin
        if (lt) begin
          dly = $urandom_range(0, 5);
          hold = $urandom_range(2, 10);
        end
        if (dly > 0) begin
          dly--;
          busy = 1'b0;
        end else if (hold > 0) begin
          hold--;
          busy = 1'b1;
        end else begin
          busy = 1'b0;
        end
        audio_v = ($urandom_range(0, 3) == 0);
        audio = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        tau_v = ($urandom_range(0, 11) == 0);
        tau = 11'($urandom);
        @(negedge clk);
        lt = trig;
        cons_a = 1'b0;
        if (trig) begin
          chk("rnd_trig_busy", busy, 1'b0);
          chk("rnd_gap", (c - last_c) >= 3, 1'b1);
          last_c = c;
          ets = 1'b0;
          e = '0;
          if (m_mid) begin
            e = {5'd0, m_fr};
            ets = 1'b1;
            m_mid = 1'b0;
            m_starve = 0;
          end else if (m_tp && (!m_ap || m_starve >= 8)) begin
            e = 16'hFFFF;
            m_mid = 1'b1;
            m_fr = m_t;
            m_tp = 1'b0;
          end else if (m_ap) begin
            e = (m_a == 16'hFFFF) ? 16'hFFFE : m_a;
            m_ap = 1'b0;
            cons_a = 1'b1;
            m_starve = m_tp ? ((m_starve < 8) ? m_starve + 1 : 8) : 0;
          end else begin
            chk("rnd_spurious_trig", 1'b1, 1'b0);
          end
          chk("rnd_data", data, e);
          chk("rnd_ts", tsent, ets);
        end else begin
          chk("rnd_ts_idle", tsent, 1'b0);
        end
        if (audio_v) begin
          if (m_ap && !cons_a && m_drop < 65535) m_drop++;
          m_ap = 1'b1;
          m_a = audio;
        end
        if (tau_v) begin
          m_tp = 1'b1;
          m_t = tau;
        end
        chk("rnd_drop", drop, m_drop);
        if ((m_ap || m_tp || m_mid) && !trig) stall++;
        else stall = 0;
        if (stall > max_stall) max_stall = stall;
      end
      chk("rnd_max_stall_ok", max_stall <= 80, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
